regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the ARMv4 general-purpose register file between two requesters: requester 0 is ALU/writeback and requester 1 is the load/LDM unit. It uses round-robin arbitration with a valid/ready handshake on each requester. Requester 1 can lock the port for back-to-back LDM beats. Output is a registered write strobe, address and data that drive the register-file instances directly.

## Interface
Parameters:
- DATA_SIZE, 32, width of write data
- ADDR_SIZE, 4, register index width (R0–R15)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ0_VALID  in  1  requester 0 has a write pending
- REQ0_ADDR  in  ADDR_SIZE  requester 0 destination register
- REQ0_DATA  in  DATA_SIZE  requester 0 write data
- REQ0_READY  out  1  requester 0 write accepted this cycle
- REQ1_VALID  in  1  requester 1 has a write pending
- REQ1_ADDR  in  ADDR_SIZE  requester 1 destination register
- REQ1_DATA  in  DATA_SIZE  requester 1 write data
- REQ1_LOCK  in  1  requester 1 holds the port after this beat (LDM burst continues)
- REQ1_READY  out  1  requester 1 write accepted this cycle
- WR_EN  out  1  register-file write strobe, one cycle per accepted write
- WR_ADDR  out  ADDR_SIZE  register-file write index
- WR_DATA  out  DATA_SIZE  register-file write data
- LOCKED  out  1  port currently locked to requester 1

## Operation
- Handshake: a transfer occurs on requester i when VALID_i && READY_i at a rising CLK edge. READY is combinational from VALID and state. VALID must stay asserted with stable ADDR/DATA until accepted.
- At most one transfer per cycle. No bubble is required between transfers.
- State machine (2 states, ARB_IDLE / ARB_LOCKED):
  - ARB_IDLE: READY0 = VALID0 && (!VALID1 || PRIO==0); READY1 = VALID1 && (!VALID0 || PRIO==1).
  - ARB_IDLE -> ARB_LOCKED on a requester-1 transfer with REQ1_LOCK=1.
  - ARB_LOCKED: READY0 = 0; READY1 = VALID1.
  - ARB_LOCKED -> ARB_IDLE on a requester-1 transfer with REQ1_LOCK=0.
  - ARB_LOCKED persists while VALID1=0. Requester 1 owns the port until it closes the burst.
- PRIO (1-bit round-robin pointer): after a transfer by requester i, PRIO <= ~i. PRIO is not updated in ARB_LOCKED except on the closing beat, which sets PRIO <= 0.
- Output register: on a transfer, WR_EN <= 1, WR_ADDR <= ADDR_i, WR_DATA <= DATA_i. With no transfer, WR_EN <= 0 and WR_ADDR/WR_DATA hold their previous value.
- Same address from both requesters in the same cycle: no merging. The loser is written in a later cycle, so the later write wins in the register file.
- LOCKED = (state == ARB_LOCKED).

## Timing
- Latency: transfer at edge N -> WR_EN high during cycle N+1 (exactly one cycle).
- Throughput: one write per cycle. Alternating grants when both requesters hold VALID continuously in ARB_IDLE.
- Reset (async, immediate on RST rise): state = ARB_IDLE, PRIO = 0, WR_EN = 0, WR_ADDR = 0, WR_DATA = 0. Combinationally, LOCKED = 0, and READY0/READY1 follow the ARB_IDLE rules.
- Reset mid-burst: the lock is dropped and any pending output strobe is cancelled. No write is issued for the edge at which RST is high.
- RST deassertion: the first transfer is possible on the first rising edge with RST low.

## Structure
- Shared package regfile_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}
  - localparam REQ_ALU = 0, REQ_LDM = 1
  - reset constants for the WR_* outputs
- One sub-module, regfile_write_stage: the registered WR_EN/WR_ADDR/WR_DATA output stage with async reset, parameterised by DATA_SIZE/ADDR_SIZE.
- Arbitration logic, FSM and PRIO live in the top module.

## Test plan
- Reset: assert RST mid-cycle with WR_EN=1 -> WR_EN, WR_ADDR, WR_DATA, LOCKED go to 0 immediately, before the next edge.
- Single requester: REQ0 writes R3=32'h0000_00A5 -> REQ0_READY=1 same cycle; next cycle WR_EN=1, WR_ADDR=3, WR_DATA=32'h0000_00A5; following cycle WR_EN=0.
- Contention after reset: both VALID for 4 cycles (R1/32'h11 on REQ0, R2/32'h22 on REQ1, new values each beat) -> grants 0,1,0,1 and WR_ADDR sequence 1,2,1,2 one cycle delayed.
- LDM lock: REQ1 issues R4..R7 with LOCK=1,1,1,0 while REQ0 holds VALID -> REQ0_READY=0 throughout; LOCKED high from after beat 1 until after beat 4; next grant goes to REQ0.
- Lock gap: in ARB_LOCKED, REQ1_VALID=0 for 3 cycles with REQ0 valid -> LOCKED stays 1, REQ0_READY=0, WR_EN=0.
- Reset mid-burst: RST pulse after 2 of 4 locked beats -> state ARB_IDLE, LOCKED=0, and REQ0 is granted on the first edge after RST falls.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Requester indices double as the round-robin priority encoding.
package regfile_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int REQ_ALU = 0;
  localparam int REQ_LDM = 1;

  localparam logic PRIO_RST    = 1'b0;
  localparam logic WR_EN_RST   = 1'b0;
  localparam int   WR_ADDR_RST = 0;
  localparam int   WR_DATA_RST = 0;

endpackage

// File: rtl/regfile_write_stage.sv
// Registered write strobe/address/data feeding the register-file instances.
// Address and data hold their last value when no write is accepted.
module regfile_write_stage
  import regfile_arb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] data,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [DATA_SIZE-1:0] wr_data
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= WR_EN_RST;
      wr_addr <= ADDR_SIZE'(WR_ADDR_RST);
      wr_data <= DATA_SIZE'(WR_DATA_RST);
    end else begin
      wr_en <= load;
      if (load) begin
        wr_addr <= addr;
        wr_data <= data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// writeback (requester 0) and the load/LDM unit (requester 1, lockable).
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  input  logic [ADDR_SIZE-1:0] REQ0_ADDR,
  input  logic [DATA_SIZE-1:0] REQ0_DATA,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_SIZE-1:0] REQ1_ADDR,
  input  logic [DATA_SIZE-1:0] REQ1_DATA,
  input  logic                 REQ1_LOCK,
  output logic                 REQ1_READY,
  output logic                 WR_EN,
  output logic [ADDR_SIZE-1:0] WR_ADDR,
  output logic [DATA_SIZE-1:0] WR_DATA,
  output logic                 LOCKED
);

  arb_state_t state, next_state;
  logic       prio, next_prio;
  logic       xfer;
  logic [ADDR_SIZE-1:0] xfer_addr;
  logic [DATA_SIZE-1:0] xfer_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB_IDLE;
      prio  <= PRIO_RST;
    end else begin
      state <= next_state;
      prio  <= next_prio;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    next_state = state;
    next_prio  = prio;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        REQ0_READY = REQ0_VALID && (!REQ1_VALID || prio == 1'(REQ_ALU));
        REQ1_READY = REQ1_VALID && (!REQ0_VALID || prio == 1'(REQ_LDM));
        if (REQ1_READY) begin
          next_prio = 1'(REQ_ALU);
          if (REQ1_LOCK) next_state = ARB_LOCKED;
        end else if (REQ0_READY) begin
          next_prio = 1'(REQ_LDM);
        end
      end
      ARB_LOCKED: begin
        // The LDM unit owns the port until its closing beat, even across gaps.
        REQ1_READY = REQ1_VALID;
        if (REQ1_VALID && !REQ1_LOCK) begin
          next_state = ARB_IDLE;
          next_prio  = 1'(REQ_ALU);
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  assign xfer      = REQ0_READY || REQ1_READY;
  assign xfer_addr = REQ1_READY ? REQ1_ADDR : REQ0_ADDR;
  assign xfer_data = REQ1_READY ? REQ1_DATA : REQ0_DATA;
  assign LOCKED    = (state == ARB_LOCKED);

  regfile_write_stage #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_write_stage (
    .clk    (CLK),
    .rst    (RST),
    .load   (xfer),
    .addr   (xfer_addr),
    .data   (xfer_data),
    .wr_en  (WR_EN),
    .wr_addr(WR_ADDR),
    .wr_data(WR_DATA)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a small arbitration model pushes
// expected writes when stimulus is granted; they are popped one cycle later.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr  = '0;
  logic [DW-1:0] req0_data  = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr  = '0;
  logic [DW-1:0] req1_data  = '0;
  logic          req1_lock  = 1'b0;
  logic          req1_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          locked;

  int  total = 0;
  int  bad   = 0;
  wr_t q[$];
  bit  m_locked = 1'b0;
  bit  m_prio   = 1'b0;

  regfile_write_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(req0_valid), .REQ0_ADDR(req0_addr), .REQ0_DATA(req0_data), .REQ0_READY(req0_ready),
    .REQ1_VALID(req1_valid), .REQ1_ADDR(req1_addr), .REQ1_DATA(req1_data), .REQ1_LOCK(req1_lock),
    .REQ1_READY(req1_ready),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .LOCKED(locked)
  );

  always #5 clk = ~clk;

  function automatic bit m_rdy0();
    if (m_locked) return 1'b0;
    return req0_valid && (!req1_valid || m_prio == 1'b0);
  endfunction

  function automatic bit m_rdy1();
    if (m_locked) return req1_valid;
    return req1_valid && (!req0_valid || m_prio == 1'b1);
  endfunction

  task automatic set_in(input bit v0, input int a0, input logic [DW-1:0] d0,
                        input bit v1, input int a1, input logic [DW-1:0] d1, input bit lk);
    @(negedge clk);
    req0_valid = v0; req0_addr = AW'(a0); req0_data = d0;
    req1_valid = v1; req1_addr = AW'(a1); req1_data = d1; req1_lock = lk;
    #1;
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_prio   = 1'b0;
    q.delete();
  endtask

  // Model update and scoreboard push for the coming rising edge, then settle.
  task automatic advance();
    bit r0, r1;
    r0 = m_rdy0();
    r1 = m_rdy1();
    if (!rst) begin
      if (r1) begin
        q.push_back('{req1_addr, req1_data});
        if (!m_locked) begin
          m_prio   = 1'b0;
          m_locked = req1_lock;
        end else if (!req1_lock) begin
          m_locked = 1'b0;
          m_prio   = 1'b0;
        end
      end else if (r0) begin
        q.push_back('{req0_addr, req0_data});
        m_prio = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_t e;
    #1;
    total++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || locked !== 1'b0) begin
      bad++; $display("FAIL reset_init got en=%b a=%0d d=%h lk=%b want 0/0/0/0", wr_en, wr_addr, wr_data, locked);
    end
    @(negedge clk); rst = 1'b0;
    set_in(1, 9, 32'hDEAD_BEEF, 0, 0, 0, 0);
    advance();
    total++; if (wr_en !== 1'b1) begin
      bad++; $display("FAIL reset_pre_en got=%b want=1", wr_en);
    end
    if (q.size() != 0) e = q.pop_front();
    #2 rst = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || locked !== 1'b0) begin
      bad++; $display("FAIL reset_async got en=%b a=%0d d=%h lk=%b want 0/0/0/0", wr_en, wr_addr, wr_data, locked);
    end
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    wr_t e;
    set_in(1, 3, 32'h0000_00A5, 0, 0, 0, 0);
    total++; if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready got=%b want=1", req0_ready);
    end
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0);
    e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 32'h0000_00A5 || wr_addr !== e.addr || wr_data !== e.data) begin
      bad++; $display("FAIL single_write got en=%b a=%0d d=%h want en=1 a=3 d=000000a5", wr_en, wr_addr, wr_data);
    end
    advance();
    total++; if (wr_en !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL single_idle got en=%b want=0", wr_en);
    end
  endtask

  task automatic test_contention();
    wr_t e;
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 32'h11 + DW'(i * 'h100), 1, 2, 32'h22 + DW'(i * 'h100), 0);
      total++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1) || req0_ready !== m_rdy0()) begin
        bad++; $display("FAIL contend_grant beat=%0d got r0=%b r1=%b want r0=%b r1=%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      end
      advance();
      e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
      total++; if (wr_en !== 1'b1 || wr_addr !== AW'((i % 2) + 1) || wr_addr !== e.addr || wr_data !== e.data) begin
        bad++; $display("FAIL contend_write beat=%0d got en=%b a=%0d d=%h want a=%0d d=%h", i, wr_en, wr_addr, wr_data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_ldm_lock();
    wr_t e;
    set_in(1, 10, 32'hA0A0, 0, 0, 0, 0);
    advance();
    if (q.size() != 0) e = q.pop_front();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 8, 32'h8888, 1, 4 + i, 32'h4000 + DW'(i), i < 3);
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
        bad++; $display("FAIL lock_grant beat=%0d got r0=%b r1=%b want r0=0 r1=1", i, req0_ready, req1_ready);
      end
      advance();
      e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
      total++; if (wr_en !== 1'b1 || wr_addr !== AW'(4 + i) || wr_data !== e.data || locked !== (i < 3)) begin
        bad++; $display("FAIL lock_write beat=%0d got en=%b a=%0d d=%h lk=%b want a=%0d d=%h lk=%b", i, wr_en, wr_addr, wr_data, locked, 4 + i, e.data, i < 3);
      end
    end
    set_in(1, 8, 32'h8888, 0, 0, 0, 0);
    total++; if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL lock_after got r0=%b want=1", req0_ready);
    end
    advance();
    e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd8 || wr_data !== 32'h8888) begin
      bad++; $display("FAIL lock_after_write got en=%b a=%0d d=%h want en=1 a=8 d=00008888", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_lock_gap();
    wr_t e;
    set_in(0, 0, 0, 1, 12, 32'hC0C0, 1);
    advance();
    if (q.size() != 0) e = q.pop_front();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5, 32'h5555, 0, 0, 0, 1);
      total++; if (req0_ready !== 1'b0 || locked !== 1'b1) begin
        bad++; $display("FAIL gap_hold cyc=%0d got r0=%b lk=%b want r0=0 lk=1", i, req0_ready, locked);
      end
      advance();
      total++; if (wr_en !== 1'b0 || q.size() != 0) begin
        bad++; $display("FAIL gap_wr_en cyc=%0d got=%b want=0", i, wr_en);
      end
    end
    set_in(1, 5, 32'h5555, 1, 13, 32'hD0D0, 0);
    advance();
    e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd13 || wr_data !== 32'hD0D0 || locked !== 1'b0) begin
      bad++; $display("FAIL gap_close got en=%b a=%0d d=%h lk=%b want en=1 a=13 d=0000d0d0 lk=0", wr_en, wr_addr, wr_data, locked);
    end
    set_in(1, 5, 32'h5555, 0, 0, 0, 0);
    advance();
    e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_addr !== e.addr) begin
      bad++; $display("FAIL gap_release got en=%b a=%0d want en=1 a=5", wr_en, wr_addr);
    end
  endtask

  task automatic test_reset_burst();
    wr_t e;
    set_in(1, 1, 32'h1111, 0, 0, 0, 0);
    advance();
    if (q.size() != 0) e = q.pop_front();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 2, 32'h2222, 1, 4 + i, 32'h7000 + DW'(i), 1);
      advance();
      if (q.size() != 0) e = q.pop_front();
    end
    total++; if (locked !== 1'b1 || locked !== m_locked) begin
      bad++; $display("FAIL burst_locked got=%b want=1", locked);
    end
    set_in(1, 2, 32'h2222, 1, 6, 32'h7002, 1);
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (locked !== 1'b0 || wr_en !== 1'b0) begin
      bad++; $display("FAIL burst_rst got lk=%b en=%b want lk=0 en=0", locked, wr_en);
    end
    advance();
    total++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || q.size() != 0) begin
      bad++; $display("FAIL burst_rst_edge got en=%b a=%0d d=%h want 0/0/0", wr_en, wr_addr, wr_data);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || locked !== 1'b0) begin
      bad++; $display("FAIL burst_regrant got r0=%b r1=%b lk=%b want r0=1 r1=0 lk=0", req0_ready, req1_ready, locked);
    end
    advance();
    e = (q.size() != 0) ? q.pop_front() : '{'0, '0};
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 32'h2222 || wr_data !== e.data) begin
      bad++; $display("FAIL burst_first_write got en=%b a=%0d d=%h want en=1 a=2 d=00002222", wr_en, wr_addr, wr_data);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_ldm_lock();
    test_lock_gap();
    test_reset_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
